// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues one request at a time to a
// variable-latency instruction memory. It holds each fetched word for IF/ID
// and follows stall and redirect from ID. Responses fetched down a wrong path
// are discarded. While no real instruction is held, the stage presents an
// all-zero nop.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC_p4,
    output logic        IF_valid
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inst_buf_r;
    logic        drop_r;

    logic [31:0] target_s;
    logic [31:0] pc_p4_s;
    logic        unused_target_lsb_s;

    // A redirect target is always word aligned, so its low two bits are forced to zero.
    assign target_s            = {redirect_target[31:2], 2'b00};
    assign unused_target_lsb_s = ^redirect_target[1:0];
    // The increment is modulo 2^32, so 0xFFFFFFFC wraps to 0.
    assign pc_p4_s             = pc_r + 32'd4;

    // Fetch sequencer: PC, the wrong-path drop flag, the instruction buffer and the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_START;
            pc_r       <= RESET_PC;
            inst_buf_r <= 32'h0000_0000;
            drop_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_START: begin
                    // Redirect has no meaning before the first request and is ignored.
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    // The request at the old PC is already out. If a redirect arrives
                    // now, its response must be thrown away.
                    if (redirect) begin
                        pc_r   <= target_s;
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect || drop_r) begin
                            if (redirect) begin
                                pc_r <= target_s;
                            end else begin
                                pc_r <= pc_r;
                            end
                            drop_r  <= 1'b0;
                            state_r <= ST_REQ;
                        end else begin
                            inst_buf_r <= imem_rdata;
                            state_r    <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        // The response is still outstanding. Remember to discard it.
                        pc_r   <= target_s;
                        drop_r <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        // IF/ID flushes the presented word itself. Only the PC moves here.
                        pc_r    <= target_s;
                        state_r <= ST_REQ;
                    end else if (!stall) begin
                        pc_r    <= pc_p4_s;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_START;
                    drop_r  <= 1'b0;
                end
            endcase
        end
    end

    // Every output is decoded from registers only. No input reaches an output in the same cycle.
    assign imem_req       = (state_r == ST_REQ);
    assign imem_addr      = pc_r;
    assign IF_valid       = (state_r == ST_HOLD);
    assign IF_Instruction = IF_valid ? inst_buf_r : 32'h0000_0000;
    assign IF_PC_p4       = IF_valid ? pc_p4_s : 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit. The bench acts as the
// instruction memory itself: it drives imem_rvalid and imem_rdata directly,
// so every memory latency is spelled out row by row in the table.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC_p4;
    logic        IF_valid;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_IF_Instruction;
    logic [31:0] w_IF_PC_p4;
    logic        w_IF_valid;

    int total;
    int bad;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_Instruction(IF_Instruction), .IF_PC_p4(IF_PC_p4), .IF_valid(IF_valid)
    );

    // Second instance: it starts at the top of the address space to exercise PC wrap-around.
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_Instruction(w_IF_Instruction), .IF_PC_p4(w_IF_PC_p4), .IF_valid(w_IF_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic rd, input logic [31:0] tg,
                       input logic rv, input logic [31:0] rdat,
                       input logic ereq, input logic [31:0] eaddr, input logic evld,
                       input logic [31:0] einst, input logic [31:0] ep4);
        vec_t v;
        v.stall = st; v.redirect = rd; v.target = tg; v.rvalid = rv; v.rdata = rdat;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evld;
        v.exp_inst = einst; v.exp_p4 = ep4;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ereq, input logic [31:0] eaddr,
                            input logic evld, input logic [31:0] einst, input logic [31:0] ep4);
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, ereq});
        chk({tag, ".imem_addr"}, imem_addr, eaddr);
        chk({tag, ".IF_valid"}, {31'd0, IF_valid}, {31'd0, evld});
        chk({tag, ".IF_Instruction"}, IF_Instruction, einst);
        chk({tag, ".IF_PC_p4"}, IF_PC_p4, ep4);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tg,
                         input logic rv, input logic [31:0] rdat);
        stall = st; redirect = rd; redirect_target = tg; imem_rvalid = rv; imem_rdata = rdat;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Rows: stall, redirect, target, rvalid, rdata | req, addr, valid, inst, pc+4
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h000, 0, 32'h0,         32'h0);   // 0 START
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h000, 0, 32'h0,         32'h0);   // 1 REQ @0
        add(0, 0, 32'h0, 1, 32'h2008_0005,   0, 32'h000, 0, 32'h0,         32'h0);   // 2 WAIT, L=1
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h000, 1, 32'h2008_0005, 32'h4);   // 3 HOLD
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h004, 0, 32'h0,         32'h0);   // 4 REQ @4
        add(0, 0, 32'h0, 1, 32'h1111_1111,   0, 32'h004, 0, 32'h0,         32'h0);   // 5 WAIT
        add(1, 0, 32'h0, 0, 32'h0,           0, 32'h004, 1, 32'h1111_1111, 32'h8);   // 6 HOLD stall
        add(1, 0, 32'h0, 0, 32'h0,           0, 32'h004, 1, 32'h1111_1111, 32'h8);   // 7 stall
        add(1, 0, 32'h0, 0, 32'h0,           0, 32'h004, 1, 32'h1111_1111, 32'h8);   // 8 stall
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h004, 1, 32'h1111_1111, 32'h8);   // 9 release
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h008, 0, 32'h0,         32'h0);   // 10 REQ @8
        add(0, 1, 32'h40, 0, 32'h0,          0, 32'h008, 0, 32'h0,         32'h0);   // 11 WAIT redirect
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h040, 0, 32'h0,         32'h0);   // 12 WAIT
        add(0, 0, 32'h0, 1, 32'hDEAD_BEEF,   0, 32'h040, 0, 32'h0,         32'h0);   // 13 drop
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h040, 0, 32'h0,         32'h0);   // 14 REQ @40
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h040, 0, 32'h0,         32'h0);   // 15 WAIT
        add(0, 0, 32'h0, 1, 32'h2222_2222,   0, 32'h040, 0, 32'h0,         32'h0);   // 16 WAIT
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h040, 1, 32'h2222_2222, 32'h44);  // 17 HOLD
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h044, 0, 32'h0,         32'h0);   // 18 REQ @44
        add(0, 1, 32'h43, 1, 32'h3333_3333,  0, 32'h044, 0, 32'h0,         32'h0);   // 19 redirect+rvalid
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h040, 0, 32'h0,         32'h0);   // 20 REQ @40
        add(1, 0, 32'h0, 1, 32'h4444_4444,   0, 32'h040, 0, 32'h0,         32'h0);   // 21 kept (drop=0)
        add(1, 1, 32'h80, 0, 32'h0,          0, 32'h040, 1, 32'h4444_4444, 32'h44);  // 22 redirect beats stall
        add(0, 1, 32'h200, 0, 32'h0,         1, 32'h080, 0, 32'h0,         32'h0);   // 23 redirect in REQ
        add(0, 0, 32'h0, 1, 32'h5555_5555,   0, 32'h200, 0, 32'h0,         32'h0);   // 24 drop
        add(0, 0, 32'h0, 0, 32'h0,           1, 32'h200, 0, 32'h0,         32'h0);   // 25 REQ @200
        add(0, 0, 32'h0, 1, 32'h6666_6666,   0, 32'h200, 0, 32'h0,         32'h0);   // 26 WAIT
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h200, 1, 32'h6666_6666, 32'h204); // 27 HOLD
        add(0, 0, 32'h0, 1, 32'h7777_7777,   1, 32'h204, 0, 32'h0,         32'h0);   // 28 stray rvalid in REQ
        add(0, 1, 32'h300, 0, 32'h0,         0, 32'h204, 0, 32'h0,         32'h0);   // 29 WAIT redirect
        add(0, 0, 32'h0, 0, 32'h0,           0, 32'h300, 0, 32'h0,         32'h0);   // 30 WAIT, drop pending

        // Reset is held over two edges, and the stage must sit at its reset values.
        @(posedge clk);
        @(negedge clk);
        chk_outs("in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            chk_outs($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                     vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_p4);
            if (i == 1) chk("wrap.addr_req", w_imem_addr, 32'hFFFF_FFFC);
            if (i == 3) begin
                chk("wrap.IF_valid", {31'd0, w_IF_valid}, 32'd1);
                chk("wrap.IF_PC_p4", w_IF_PC_p4, 32'h0);
            end
            if (i == 4) begin
                chk("wrap.next_req", {31'd0, w_imem_req}, 32'd1);
                chk("wrap.next_addr", w_imem_addr, 32'h0);
            end
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].target, vecs[i].rvalid, vecs[i].rdata);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset arrives in the middle of WAIT while a drop is pending.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_outs("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        // A redirect in START must be ignored.
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_outs("restart_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk_outs("restart_wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        // With the drop cleared by reset, this response must be kept.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8888_8888);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_outs("restart_hold", 1'b0, 32'h0, 1'b1, 32'h8888_8888, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
